// File: rtl/bulls_cows_engine.sv
// bulls_cows_engine: 1A2B (bulls/cows) scoring engine with game-flow FSM.
// Loads a secret answer, accepts guesses over valid/ready, scores one digit
// per clock, counts tries and flags win/lose.
// Optional feature macro: DUP_REJECT_EN (reject guesses containing repeated digits).
module bulls_cows_engine #(
  parameter int N_DIGITS  = 4,
  parameter int DIGIT_W   = 4,
  parameter int MAX_TRIES = 18,
  localparam int W  = N_DIGITS * DIGIT_W,
  localparam int CW = $clog2(N_DIGITS + 1),
  localparam int TW = $clog2(MAX_TRIES + 1)
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  answer_in,
  input  logic          guess_valid,
  output logic          guess_ready,
  input  logic [W-1:0]  guess_in,
  output logic [CW-1:0] a_cnt,
  output logic [CW-1:0] b_cnt,
  output logic          score_valid,
  output logic [TW-1:0] tries,
  output logic          win,
  output logic          lose,
  output logic          dup_err,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    SCORE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [W-1:0]  answer_reg;
  logic [W-1:0]  guess_reg;
  logic [CW-1:0] idx_reg;
  logic [CW-1:0] a_acc_reg;
  logic [CW-1:0] b_acc_reg;
  logic [CW-1:0] a_cnt_reg;
  logic [CW-1:0] b_cnt_reg;
  logic [TW-1:0] tries_reg;
  logic          score_valid_reg;
  logic          win_reg;
  logic          lose_reg;
  logic          dup_err_reg;

  logic          accept;
  logic          load_ok;
  logic          dup_guess;
  logic          cur_bull;
  logic          cur_cow;
  logic          scan_done;

  // Digit views of the latched answer and guess
  logic [DIGIT_W-1:0] ans_digits [N_DIGITS];
  logic [DIGIT_W-1:0] gue_digits [N_DIGITS];

  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digits
      assign ans_digits[gi] = answer_reg[gi*DIGIT_W +: DIGIT_W];
      assign gue_digits[gi] = guess_reg[gi*DIGIT_W +: DIGIT_W];
    end
  endgenerate

`ifdef DUP_REJECT_EN
  logic [DIGIT_W-1:0] in_digits [N_DIGITS];

  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_in_digits
      assign in_digits[gi] = guess_in[gi*DIGIT_W +: DIGIT_W];
    end
  endgenerate

  // Flag an incoming guess that repeats any digit
  always_comb begin
    dup_guess = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      for (int j = i + 1; j < N_DIGITS; j++) begin
        if (in_digits[i] == in_digits[j]) dup_guess = 1'b1;
      end
    end
  end
`else
  assign dup_guess = 1'b0;
`endif

  assign accept    = guess_valid & guess_ready & ~load;
  assign load_ok   = load & (state_reg != SCORE);
  assign scan_done = (idx_reg == CW'(N_DIGITS));

  // Classify the digit under the scan pointer as bull, cow or miss
  always_comb begin
    cur_bull = 1'b0;
    cur_cow  = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_reg == CW'(i)) begin
        if (gue_digits[i] == ans_digits[i]) begin
          cur_bull = 1'b1;
        end else begin
          for (int j = 0; j < N_DIGITS; j++) begin
            if (j != i && gue_digits[i] == ans_digits[j]) cur_cow = 1'b1;
          end
        end
      end
    end
  end

  // Game-flow state register
  always_ff @(posedge CLK) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; the final SCORE cycle decides win/lose/continue
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (load) state_next = PLAY;
      PLAY: begin
        if (load)                        state_next = PLAY;
        else if (accept && !dup_guess)   state_next = SCORE;
      end
      SCORE: begin
        if (scan_done) begin
          if (a_acc_reg == CW'(N_DIGITS))        state_next = DONE;
          else if (tries_reg == TW'(MAX_TRIES))  state_next = DONE;
          else                                   state_next = PLAY;
        end
      end
      DONE:  if (load) state_next = PLAY;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: answer/guess capture, serial scoring, try counting, result flags
  always_ff @(posedge CLK) begin
    if (rst) begin
      answer_reg      <= '0;
      guess_reg       <= '0;
      idx_reg         <= '0;
      a_acc_reg       <= '0;
      b_acc_reg       <= '0;
      a_cnt_reg       <= '0;
      b_cnt_reg       <= '0;
      tries_reg       <= '0;
      score_valid_reg <= 1'b0;
      win_reg         <= 1'b0;
      lose_reg        <= 1'b0;
      dup_err_reg     <= 1'b0;
    end else begin
      score_valid_reg <= 1'b0;
      dup_err_reg     <= 1'b0;
      if (load_ok) begin
        answer_reg <= answer_in;
        tries_reg  <= '0;
        a_cnt_reg  <= '0;
        b_cnt_reg  <= '0;
        win_reg    <= 1'b0;
        lose_reg   <= 1'b0;
      end else begin
        case (state_reg)
          PLAY: begin
            if (accept) begin
              if (dup_guess) begin
                dup_err_reg <= 1'b1;
              end else begin
                guess_reg <= guess_in;
                tries_reg <= tries_reg + TW'(1);
                a_acc_reg <= '0;
                b_acc_reg <= '0;
                idx_reg   <= '0;
              end
            end
          end
          SCORE: begin
            if (!scan_done) begin
              a_acc_reg <= a_acc_reg + CW'(cur_bull);
              b_acc_reg <= b_acc_reg + CW'(cur_cow);
              idx_reg   <= idx_reg + CW'(1);
            end else begin
              a_cnt_reg       <= a_acc_reg;
              b_cnt_reg       <= b_acc_reg;
              score_valid_reg <= 1'b1;
              if (a_acc_reg == CW'(N_DIGITS))       win_reg  <= 1'b1;
              else if (tries_reg == TW'(MAX_TRIES)) lose_reg <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign guess_ready = (state_reg == PLAY);
  assign a_cnt       = a_cnt_reg;
  assign b_cnt       = b_cnt_reg;
  assign score_valid = score_valid_reg;
  assign tries       = tries_reg;
  assign win         = win_reg;
  assign lose        = lose_reg;
  assign dup_err     = dup_err_reg;
  assign state       = state_reg;

endmodule

// File: tb/tb_bulls_cows_engine.sv
// tb_bulls_cows_engine: directed and randomized checks of the bulls/cows engine
// against a game-rule reference model (N_DIGITS=4, DIGIT_W=4, MAX_TRIES=3).
module tb_bulls_cows_engine;
  localparam int N  = 4;
  localparam int DW = 4;
  localparam int MT = 3;
  localparam int W  = N * DW;
  localparam int CW = $clog2(N + 1);
  localparam int TW = $clog2(MT + 1);

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [W-1:0]  answer_in = '0;
  logic          guess_valid = 1'b0;
  logic          guess_ready;
  logic [W-1:0]  guess_in = '0;
  logic [CW-1:0] a_cnt;
  logic [CW-1:0] b_cnt;
  logic          score_valid;
  logic [TW-1:0] tries;
  logic          win;
  logic          lose;
  logic          dup_err;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  bulls_cows_engine #(.N_DIGITS(N), .DIGIT_W(DW), .MAX_TRIES(MT)) dut (
    .CLK(CLK), .rst(rst), .load(load), .answer_in(answer_in),
    .guess_valid(guess_valid), .guess_ready(guess_ready), .guess_in(guess_in),
    .a_cnt(a_cnt), .b_cnt(b_cnt), .score_valid(score_valid), .tries(tries),
    .win(win), .lose(lose), .dup_err(dup_err), .state(state)
  );

  always #5 CLK = ~CLK;

  // Reference model: bulls are positional matches; a non-bull guess digit is a
  // cow if it appears anywhere else in the answer
  function automatic void model_score(input logic [W-1:0] ans, input logic [W-1:0] g,
                                      output int a, output int b);
    int ad[N];
    int gd[N];
    a = 0;
    b = 0;
    for (int i = 0; i < N; i++) begin
      ad[i] = int'(ans[i*DW +: DW]);
      gd[i] = int'(g[i*DW +: DW]);
    end
    for (int i = 0; i < N; i++) begin
      if (gd[i] == ad[i]) a++;
      else begin
        bit hit = 0;
        for (int j = 0; j < N; j++) if (j != i && gd[i] == ad[j]) hit = 1;
        if (hit) b++;
      end
    end
  endfunction

  function automatic bit model_dup(input logic [W-1:0] g);
    bit d = 0;
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        if (g[i*DW +: DW] == g[j*DW +: DW]) d = 1;
    return d;
  endfunction

  function automatic logic [W-1:0] rand_code();
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom_range(0, 5));
    return v;
  endfunction

  // Starts and ends on a falling edge
  task automatic do_load(input logic [W-1:0] ans);
    load = 1'b1;
    answer_in = ans;
    @(negedge CLK);
    load = 1'b0;
  endtask

  // Offers one guess; lat = falling edges from offer to score_valid (-1 if none)
  task automatic do_guess(input logic [W-1:0] g, output int lat, output logic dseen);
    lat = -1;
    dseen = 1'b0;
    guess_valid = 1'b1;
    guess_in = g;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        guess_valid = 1'b0;
        dseen = dup_err;
      end
      if (score_valid) begin
        lat = k;
        break;
      end
      if (dseen && k == 4) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (tries !== '0) begin errors++; $display("FAIL reset_tries: got %0d expected 0", tries); end
    checks++; if ({a_cnt, b_cnt} !== '0) begin errors++; $display("FAIL reset_cnt: got a=%0d b=%0d expected 0 0", a_cnt, b_cnt); end
    checks++; if ({score_valid, win, lose, dup_err, guess_ready} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {score_valid, win, lose, dup_err, guess_ready}); end
    rst = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_win_first_try();
    int lat; logic ds;
    do_load(16'h1234);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL load_state: got %0d expected 1", state); end
    do_guess(16'h1234, lat, ds);
    checks++; if (lat != N + 2) begin errors++; $display("FAIL win_latency: got %0d expected %0d", lat, N + 2); end
    checks++; if (a_cnt !== 3'd4 || b_cnt !== 3'd0) begin errors++; $display("FAIL win_score: got a=%0d b=%0d expected 4 0", a_cnt, b_cnt); end
    checks++; if (win !== 1'b1 || lose !== 1'b0 || state !== 2'd3) begin errors++; $display("FAIL win_flags: got win=%b lose=%b state=%0d expected 1 0 3", win, lose, state); end
    @(negedge CLK);
    checks++; if (score_valid !== 1'b0 || guess_ready !== 1'b0 || win !== 1'b1) begin errors++; $display("FAIL win_hold: got sv=%b rdy=%b win=%b expected 0 0 1", score_valid, guess_ready, win); end
  endtask

  task automatic test_mixed_scores();
    int lat; logic ds;
    do_load(16'h1234);
    checks++; if (win !== 1'b0 || tries !== '0) begin errors++; $display("FAIL load_clear: got win=%b tries=%0d expected 0 0", win, tries); end
    do_guess(16'h4321, lat, ds);
    checks++; if (a_cnt !== 3'd0 || b_cnt !== 3'd4 || tries !== 2'd1) begin errors++; $display("FAIL g4321: got a=%0d b=%0d t=%0d expected 0 4 1", a_cnt, b_cnt, tries); end
    do_guess(16'h1243, lat, ds);
    checks++; if (a_cnt !== 3'd2 || b_cnt !== 3'd2 || tries !== 2'd2 || state !== 2'd1) begin errors++; $display("FAIL g1243: got a=%0d b=%0d t=%0d s=%0d expected 2 2 2 1", a_cnt, b_cnt, tries, state); end
  endtask

  task automatic test_lose_and_last_win();
    int lat; logic ds;
    do_load(16'h1234);
    for (int i = 0; i < MT; i++) begin
      do_guess(16'h5678, lat, ds);
      checks++; if (a_cnt !== 3'd0 || b_cnt !== 3'd0 || lat != N + 2) begin errors++; $display("FAIL miss%0d: got a=%0d b=%0d lat=%0d expected 0 0 %0d", i, a_cnt, b_cnt, lat, N + 2); end
    end
    checks++; if (lose !== 1'b1 || win !== 1'b0 || state !== 2'd3 || tries !== 2'd3) begin errors++; $display("FAIL lose: got lose=%b win=%b s=%0d t=%0d expected 1 0 3 3", lose, win, state, tries); end
    do_load(16'h1234);
    do_guess(16'h5678, lat, ds);
    do_guess(16'h5678, lat, ds);
    do_guess(16'h1234, lat, ds);
    checks++; if (win !== 1'b1 || lose !== 1'b0 || state !== 2'd3 || tries !== 2'd3) begin errors++; $display("FAIL last_try_win: got win=%b lose=%b s=%0d t=%0d expected 1 0 3 3", win, lose, state, tries); end
  endtask

  task automatic test_reset_mid_score();
    int seen = 0;
    do_load(16'h1234);
    guess_valid = 1'b1;
    guess_in = 16'h1234;
    @(negedge CLK);
    guess_valid = 1'b0;
    @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
    checks++; if (state !== 2'd0 || tries !== '0 || a_cnt !== '0) begin errors++; $display("FAIL abort_reset: got s=%0d t=%0d a=%0d expected 0 0 0", state, tries, a_cnt); end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (score_valid) seen++;
    end
    checks++; if (seen != 0 || win !== 1'b0) begin errors++; $display("FAIL abort_no_score: got pulses=%0d win=%b expected 0 0", seen, win); end
  endtask

  task automatic test_load_priority();
    int lat; logic ds; int seen = 0;
    do_load(16'h1234);
    load = 1'b1;
    answer_in = 16'h5678;
    guess_valid = 1'b1;
    guess_in = 16'h1234;
    @(negedge CLK);
    load = 1'b0;
    guess_valid = 1'b0;
    checks++; if (tries !== '0 || state !== 2'd1) begin errors++; $display("FAIL load_prio: got t=%0d s=%0d expected 0 1", tries, state); end
    for (int k = 0; k < 7; k++) begin
      @(negedge CLK);
      if (score_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL load_prio_drop: got pulses=%0d expected 0", seen); end
    do_guess(16'h5678, lat, ds);
    checks++; if (win !== 1'b1 || a_cnt !== 3'd4 || tries !== 2'd1) begin errors++; $display("FAIL load_prio_win: got win=%b a=%0d t=%0d expected 1 4 1", win, a_cnt, tries); end
  endtask

  task automatic test_duplicate_guess();
    int lat; logic ds;
    do_load(16'h1234);
    do_guess(16'h1123, lat, ds);
`ifdef DUP_REJECT_EN
    checks++; if (ds !== 1'b1 || lat != -1) begin errors++; $display("FAIL dup_reject: got dup=%b lat=%0d expected 1 -1", ds, lat); end
    checks++; if (tries !== '0 || state !== 2'd1 || dup_err !== 1'b0) begin errors++; $display("FAIL dup_state: got t=%0d s=%0d dup=%b expected 0 1 0", tries, state, dup_err); end
`else
    checks++; if (a_cnt !== 3'd1 || b_cnt !== 3'd3 || ds !== 1'b0) begin errors++; $display("FAIL dup_score: got a=%0d b=%0d dup=%b expected 1 3 0", a_cnt, b_cnt, ds); end
    checks++; if (tries !== 2'd1 || state !== 2'd1) begin errors++; $display("FAIL dup_tries: got t=%0d s=%0d expected 1 1", tries, state); end
`endif
  endtask

  task automatic test_random_games();
    logic [W-1:0] ans, g;
    int ea, eb, lat, etries;
    logic ds;
    bit over, edup, ewin, elose;
    for (int game = 0; game < 25; game++) begin
      ans = rand_code();
      do_load(ans);
      etries = 0;
      over = 0;
      for (int att = 0; att < 10 && !over; att++) begin
        g = ($urandom_range(0, 3) == 0) ? ans : rand_code();
        edup = 0;
`ifdef DUP_REJECT_EN
        edup = model_dup(g);
`endif
        model_score(ans, g, ea, eb);
        do_guess(g, lat, ds);
        if (edup) begin
          checks++; if (ds !== 1'b1 || lat != -1 || tries !== TW'(etries) || state !== 2'd1) begin errors++; $display("FAIL rnd_dup g%0d: guess=%h got dup=%b lat=%0d t=%0d s=%0d expected 1 -1 %0d 1", game, g, ds, lat, tries, state, etries); end
        end else begin
          etries++;
          ewin = (ea == N);
          elose = !ewin && (etries == MT);
          over = ewin || elose;
          checks++; if (lat != N + 2 || a_cnt !== CW'(ea) || b_cnt !== CW'(eb) || tries !== TW'(etries)) begin errors++; $display("FAIL rnd_score g%0d: ans=%h guess=%h got lat=%0d a=%0d b=%0d t=%0d expected %0d %0d %0d %0d", game, ans, g, lat, a_cnt, b_cnt, tries, N + 2, ea, eb, etries); end
          checks++; if (win !== ewin || lose !== elose || state !== (over ? 2'd3 : 2'd1)) begin errors++; $display("FAIL rnd_flags g%0d: got win=%b lose=%b s=%0d expected %b %b %0d", game, win, lose, state, ewin, elose, over ? 3 : 1); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_win_first_try();
    test_mixed_scores();
    test_lose_and_last_win();
    test_reset_mid_score();
    test_load_priority();
    test_duplicate_guess();
    test_random_games();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
